// File: rtl/watch_pkg.sv
// Shared constants and types for the watch top level.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package watch_pkg;

  // Button indices inside the 6-bit button/event vectors.
  localparam int NUM_BTN   = 6;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_ENTER = 4;
  localparam int BTN_ESC   = 5;

  // All segments off.
  localparam logic [7:0] BLANK_SEG = 8'hFF;

  // Mode indices, in esc cycling order.
  localparam int MODE_W      = 3;
  localparam int MODE_DATE   = 0;
  localparam int MODE_CLOCK  = 1;
  localparam int MODE_ALARM  = 2;
  localparam int MODE_STOPW  = 3;
  localparam int MODE_TIMER  = 4;
  localparam int MODE_DDAY   = 5;
  localparam int MODE_LADDER = 6;

  typedef enum logic {
    RUN   = 1'b0,
    ALARM = 1'b1
  } state_e;

endpackage

// File: rtl/watch_btn_cond.sv
// Button conditioner: 2-flop sync, rising-edge event, optional hold auto-repeat.
// Latency: press event registered 3 cycles after the raw level is first sampled.
// Backpressure: none; events are single-cycle pulses.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   btn_i       raw button level, asynchronous to clk
//   ev_o        one-cycle event per press (plus repeats when REPEAT_EN)
module watch_btn_cond
  import watch_pkg::*;
#(
  parameter bit REPEAT_EN = 1'b0,
  parameter int HOLD_CYC  = 500000,
  parameter int REP_CYC   = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic ev_o
);

  localparam int CNT_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic             sync1_q, sync2_q;
  logic             lvl_q;            // sync2 delayed one cycle, for edge detect
  logic             ev_q, ev_d;
  logic             rep_q, rep_d;     // hold period done, now in repeat phase
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc, limit;

  always_comb begin
    ev_d    = 1'b0;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    cnt_inc = cnt_q + CNT_W'(1);
    limit   = rep_q ? CNT_W'(REP_CYC) : CNT_W'(HOLD_CYC);
    if (!sync2_q) begin
      // Released: forget any hold progress.
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (!lvl_q) begin
      // Press edge: the counter measures the hold from this event.
      ev_d  = 1'b1;
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (REPEAT_EN) begin
      if (cnt_inc == limit) begin
        ev_d  = 1'b1;
        cnt_d = '0;
        rep_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      ev_q    <= 1'b0;
      rep_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      lvl_q   <= sync2_q;
      ev_q    <= ev_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ev_o = ev_q;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Mode scheduler: grants display and buttons to one mode, cycles on esc, pre-empts on alarm.
// Latency: button event 3 cycles after press; mode switch +1, display +2; alarm entry/exit +1.
// Backpressure: none; events and acks are single-cycle pulses.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   btn_i         raw buttons {esc,enter,right,left,down,up}
//   norm_i        per-mode "on idle screen" flags
//   alarm_req_i   per-mode level alarm requests
//   seg_i         per-mode display, mode m in slice m
//   ev_o          per-mode button events, mode m in slice m
//   ack_o         per-mode one-cycle alarm acknowledge
//   seg_o         registered display of the active mode
//   mode_o        active mode index
//   mode_led_o    one-hot active mode indicator
//   alarm_o       buzzer enable
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int NUM_MODES = 7,
  parameter int DIGITS    = 6,
  parameter int SEG_W     = 8,
  parameter int HOLD_CYC  = 500000,
  parameter int REP_CYC   = 100000,
  parameter int ALARM_CYC = 30000000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_BTN-1:0]                btn_i,
  input  logic [NUM_MODES-1:0]              norm_i,
  input  logic [NUM_MODES-1:0]              alarm_req_i,
  input  logic [NUM_MODES*DIGITS*SEG_W-1:0] seg_i,
  output logic [NUM_MODES*NUM_BTN-1:0]      ev_o,
  output logic [NUM_MODES-1:0]              ack_o,
  output logic [DIGITS*SEG_W-1:0]           seg_o,
  output logic [2:0]                        mode_o,
  output logic [7:0]                        mode_led_o,
  output logic                              alarm_o
);

  localparam int DISP_W = DIGITS * SEG_W;
  localparam int TMR_W  = $clog2(ALARM_CYC + 1);

  logic [NUM_BTN-1:0] btn_ev;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    watch_btn_cond #(
      .REPEAT_EN ((b == BTN_UP) || (b == BTN_DOWN)),
      .HOLD_CYC  (HOLD_CYC),
      .REP_CYC   (REP_CYC)
    ) u_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_i (btn_i[b]),
      .ev_o  (btn_ev[b])
    );
  end

  state_e                 state_q, state_d;
  logic [MODE_W-1:0]      mode_q, mode_d;     // holds the alarming mode while in ALARM
  logic [MODE_W-1:0]      prev_q, prev_d;     // mode to return to after the alarm
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [TMR_W-1:0]       tmr_inc;
  logic [NUM_MODES-1:0]   req_q;
  logic [NUM_MODES-1:0]   rise;
  logic [NUM_MODES-1:0]   ack_q, ack_d;
  logic [DISP_W-1:0]      seg_q;
  logic [MODE_W-1:0]      first_rise;
  logic [MODE_W-1:0]      next_mode;
  logic [NUM_BTN-1:0]     fwd;
  logic [NUM_MODES*NUM_BTN-1:0] ev_route;

  assign rise    = alarm_req_i & ~req_q;
  assign tmr_inc = tmr_q + TMR_W'(1);

  // Wrap explicitly so a non-power-of-two mode count never reaches an unused index.
  assign next_mode = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + MODE_W'(1);

  // Lowest-index rising request wins when several rise together.
  always_comb begin
    first_rise = '0;
    for (int m = NUM_MODES - 1; m >= 0; m--) begin
      if (rise[m]) first_rise = MODE_W'(m);
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    prev_d   = prev_q;
    tmr_d    = tmr_q;
    ack_d    = '0;
    fwd      = '0;
    ev_route = '0;
    unique case (state_q)
      RUN: begin
        if (|rise) begin
          // Entry cycle: button events are dropped.
          state_d = ALARM;
          prev_d  = mode_q;
          mode_d  = first_rise;
          tmr_d   = '0;
        end else begin
          fwd = btn_ev;
          if (btn_ev[BTN_ESC] && norm_i[mode_q]) begin
            fwd[BTN_ESC] = 1'b0;
            mode_d       = next_mode;
          end
          // Buttons coinciding with a consumed esc still go to the old mode.
          ev_route[mode_q*NUM_BTN +: NUM_BTN] = fwd;
        end
      end
      ALARM: begin
        tmr_d = tmr_inc;
        // Any button acks (and is swallowed); otherwise the alarm self-clears.
        if ((|btn_ev) || (tmr_inc == TMR_W'(ALARM_CYC))) begin
          state_d       = RUN;
          mode_d        = prev_q;
          ack_d[mode_q] = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      mode_q  <= MODE_W'(MODE_DATE);
      prev_q  <= MODE_W'(MODE_DATE);
      tmr_q   <= '0;
      req_q   <= '0;
      ack_q   <= '0;
      seg_q   <= {DIGITS{BLANK_SEG}};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      prev_q  <= prev_d;
      tmr_q   <= tmr_d;
      req_q   <= alarm_req_i;
      ack_q   <= ack_d;
      seg_q   <= seg_i[mode_q*DISP_W +: DISP_W];
    end
  end

  assign ev_o       = ev_route;
  assign ack_o      = ack_q;
  assign seg_o      = seg_q;
  assign mode_o     = mode_q;
  assign mode_led_o = 8'b0000_0001 << mode_q;
  assign alarm_o    = (state_q == ALARM);

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Randomized bench for watch_mode_ctrl with a timeline reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_watch_mode_ctrl;

  localparam int NM   = 7;
  localparam int DG   = 6;
  localparam int SW   = 8;
  localparam int HOLD = 4;
  localparam int REP  = 2;
  localparam int ALM  = 20;
  localparam int MAXC = 8192;
  localparam int UP = 0, DOWN = 1, ENTER = 4, ESC = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [5:0]         btn;
  logic [NM-1:0]      norm;
  logic [NM-1:0]      areq;
  logic [NM*DG*SW-1:0] seg_in;
  logic [NM*6-1:0]    ev;
  logic [NM-1:0]      ack;
  logic [DG*SW-1:0]   seg;
  logic [2:0]         mode;
  logic [7:0]         led;
  logic               alarm;

  watch_mode_ctrl #(
    .NUM_MODES(NM), .DIGITS(DG), .SEG_W(SW),
    .HOLD_CYC(HOLD), .REP_CYC(REP), .ALARM_CYC(ALM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_i(btn), .norm_i(norm), .alarm_req_i(areq),
    .seg_i(seg_in), .ev_o(ev), .ack_o(ack), .seg_o(seg), .mode_o(mode),
    .mode_led_o(led), .alarm_o(alarm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, got, want);
    end
  endtask

  // Expected timeline, indexed by cycle number (value seen after that clock edge).
  logic [NM*6-1:0] exp_ev   [MAXC];
  logic [NM-1:0]   exp_ack  [MAXC];
  logic [2:0]      exp_mode [MAXC];
  logic            exp_alarm[MAXC];

  // Abstract model state.
  int m_mode = 0, m_prev = 0, m_a = 0, m_deadline = 0;
  bit m_alarm = 0;

  task automatic set_mode_from(input int n, input int m);
    for (int k = n; k < MAXC; k++) exp_mode[k] = 3'(m);
  endtask

  task automatic set_alarm_from(input int n, input bit v);
    for (int k = n; k < MAXC; k++) exp_alarm[k] = v;
  endtask

  // An alarm whose deadline has passed has already timed out.
  task automatic settle(input int t);
    if (m_alarm && t >= m_deadline) begin
      m_alarm = 0;
      m_mode  = m_prev;
    end
  endtask

  // A conditioned button event that the controller sees in cycle t.
  task automatic model_event(input int t, input int b);
    settle(t);
    if (m_alarm) begin
      exp_ack[m_deadline][m_a] = 1'b0;
      exp_ack[t+1][m_a]        = 1'b1;
      set_alarm_from(t + 1, 1'b0);
      set_mode_from(t + 1, m_prev);
      m_mode  = m_prev;
      m_alarm = 0;
    end else if (b == ESC && norm[m_mode]) begin
      m_mode = (m_mode + 1) % NM;
      set_mode_from(t + 1, m_mode);
    end else begin
      exp_ev[t][m_mode*6 + b] = 1'b1;
    end
  endtask

  // Hold button b for 'hold' cycles, then let the pipeline drain.
  task automatic press(input int b, input int hold);
    int p;
    @(posedge clk); #1;
    p = cyc;
    btn[b] = 1'b1;
    model_event(p + 3, b);
    // Repeats continue while the synchronized level is still high.
    if (b == UP || b == DOWN)
      for (int t = p + 3 + HOLD; t < p + hold + 3; t += REP) model_event(t, b);
    repeat (hold) @(posedge clk);
    #1 btn[b] = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic raise(input logic [NM-1:0] mask);
    logic [NM-1:0] rise;
    int d, a;
    @(posedge clk); #1;
    d    = cyc;
    rise = mask & ~areq;
    areq = areq | mask;
    settle(d);
    if (!m_alarm && rise != '0) begin
      a = 0;
      for (int m = NM - 1; m >= 0; m--) if (rise[m]) a = m;
      m_prev = m_mode; m_a = a; m_mode = a; m_alarm = 1;
      m_deadline = d + 1 + ALM;
      set_alarm_from(d + 1, 1'b1);
      set_mode_from(d + 1, a);
      // Timeout outcome; a button event earlier overrides it.
      exp_ack[m_deadline][a] = 1'b1;
      set_alarm_from(m_deadline, 1'b0);
      set_mode_from(m_deadline, m_prev);
    end
  endtask

  task automatic clear_req();
    @(posedge clk); #1 areq = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  bit mon_en = 0;
  int rel_cyc = 0;

  always @(negedge clk) begin
    int n, base;
    logic [DG*SW-1:0] ws;
    if (mon_en) begin
      n = cyc;
      base = int'(exp_mode[n-1]) * DG * SW;
      ws = (n <= rel_cyc) ? {DG{8'hFF}} : seg_in[base +: DG*SW];
      check("ev",    64'(ev),    64'(exp_ev[n]));
      check("ack",   64'(ack),   64'(exp_ack[n]));
      check("mode",  64'(mode),  64'(exp_mode[n]));
      check("led",   64'(led),   64'(8'h01 << exp_mode[n]));
      check("alarm", 64'(alarm), 64'(exp_alarm[n]));
      check("seg",   64'(seg),   64'(ws));
    end
  end

  initial begin
    int op;
    rst_n = 1'b0;
    btn   = '0;
    norm  = '0;
    areq  = '0;
    for (int i = 0; i < NM*DG; i++) seg_in[i*8 +: 8] = 8'($urandom);
    for (int k = 0; k < MAXC; k++) begin
      exp_ev[k] = '0; exp_ack[k] = '0; exp_mode[k] = '0; exp_alarm[k] = 1'b0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_mode",  64'(mode),  64'(0));
    check("rst_led",   64'(led),   64'(8'h01));
    check("rst_seg",   64'(seg),   64'(48'hFFFF_FFFF_FFFF));
    check("rst_ev",    64'(ev),    64'(0));
    check("rst_ack",   64'(ack),   64'(0));
    check("rst_alarm", 64'(alarm), 64'(0));
    @(posedge clk); #1;
    rst_n   = 1'b1;
    rel_cyc = cyc;
    mon_en  = 1;

    // Esc walks through every mode and wraps; never forwarded.
    norm = 7'h7F;
    for (int i = 0; i < 7; i++) press(ESC, 2);
    check("esc_wrap", 64'(mode), 64'(m_mode));

    // Mode 2 not on its idle screen: esc forwarded, no switch.
    press(ESC, 2);
    press(ESC, 2);
    norm = 7'h7F & ~7'h04;
    press(ESC, 2);
    check("esc_fwd_mode", 64'(mode), 64'(2));

    // Back to mode 0, hold up for auto-repeat.
    norm = 7'h7F;
    for (int i = 0; i < 5; i++) press(ESC, 2);
    press(UP, 10);
    press(DOWN, 13);

    // Two alarms rise together from mode 3: lowest wins, enter acks.
    for (int i = 0; i < 3; i++) press(ESC, 2);
    raise(7'b001_0100);
    idle(3);
    check("alarm_on", 64'(alarm), 64'(1));
    check("alarm_idx", 64'(mode), 64'(2));
    press(ENTER, 2);
    clear_req();
    check("alarm_back", 64'(mode), 64'(3));

    // Unacknowledged alarm times out.
    raise(7'b001_0000);
    idle(ALM + 6);
    clear_req();

    // Random mix of presses, alarms and idle gaps.
    for (int it = 0; it < 60 && cyc < MAXC - 300; it++) begin
      op = $urandom_range(0, 7);
      if (op <= 3) begin
        norm = 7'($urandom);
        press($urandom_range(0, 5), $urandom_range(1, 12));
      end else if (op == 4 || op == 5) begin
        raise(7'($urandom_range(1, 127)));
      end else if (op == 6) begin
        idle($urandom_range(1, 25));
      end else begin
        clear_req();
      end
    end
    clear_req();
    idle(ALM + 8);
    mon_en = 0;

    // Reset in the middle of an alarm and a held button clears at once, no ack.
    @(posedge clk); #1 areq = 7'b000_1000;
    btn[UP] = 1'b1;
    idle(3);
    #1;
    check("pre_rst_alarm", 64'(alarm), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_alarm", 64'(alarm), 64'(0));
    check("mid_rst_mode",  64'(mode),  64'(0));
    check("mid_rst_led",   64'(led),   64'(8'h01));
    check("mid_rst_ack",   64'(ack),   64'(0));
    check("mid_rst_ev",    64'(ev),    64'(0));
    check("mid_rst_seg",   64'(seg),   64'(48'hFFFF_FFFF_FFFF));
    btn  = '0;
    areq = '0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
